// File: rtl/interp2_lin_if.sv
// Stream bundle for interp2_lin: upstream sample handshake, downstream sample
// handshake and the bypass control.
interface interp2_lin_if;
  logic       bypass;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;

  modport master (
    output bypass, in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  bypass, in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/interp2_lin.sv
// 2x linear-interpolating upsampler: each input x[n] yields mid(x[n-1],x[n]) then x[n].
// Define INTERP_ROUND_EN to round the midpoint half up instead of truncating.
module interp2_lin (
  input  logic          clk,
  input  logic          rst_n,
  interp2_lin_if.slave  io
);

`ifdef INTERP_ROUND_EN
  localparam logic [8:0] RoundAdd = 9'd1;
`else
  localparam logic [8:0] RoundAdd = 9'd0;
`endif

  typedef enum logic [1:0] {IDLE, MID, CUR} state_t;

  state_t     state_q, state_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] dout_q, dout_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_c;
  logic       load_en;
  logic [7:0] load_base;

  // 9-bit sum keeps 255+255(+1) from wrapping before the shift.
  function automatic logic [7:0] mid_of(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + RoundAdd;
    return s[8:1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= 8'd0;
      cur_q       <= 8'd0;
      dout_q      <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    in_ready_c  = 1'b0;
    load_en     = 1'b0;
    load_base   = prev_q;

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        load_en    = io.in_valid;
      end
      MID: begin
        if (io.out_ready) begin
          dout_d  = cur_q;
          state_d = CUR;
        end
      end
      CUR: begin
        in_ready_c = io.out_ready;
        if (io.out_ready) begin
          prev_d = cur_q;
          // Back-to-back: the sample just emitted is the left endpoint.
          if (io.in_valid) begin
            load_en   = 1'b1;
            load_base = cur_q;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (load_en) begin
      cur_d       = io.din;
      out_valid_d = 1'b1;
      if (io.bypass) begin
        dout_d  = io.din;
        state_d = CUR;
      end else begin
        dout_d  = mid_of(load_base, io.din);
        state_d = MID;
      end
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;

endmodule

// File: tb/tb_interp2_lin.sv
// Directed bench for interp2_lin with hand-computed expected sample sequences.
module tb_interp2_lin;

`ifdef INTERP_ROUND_EN
  localparam bit Round = 1'b1;
`else
  localparam bit Round = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  interp2_lin_if bus ();

  interp2_lin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [7:0] d);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) check({tag, ".dout"}, 32'(bus.dout), 32'(d));
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".rst_dout"}, 32'(bus.dout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check({tag, ".rel_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.bypass    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = 8'd0;
    bus.out_ready = 1'b1;
    tick();

    // Power-on reset state
    check("por.valid", 32'(bus.out_valid), 32'd0);
    check("por.dout", 32'(bus.dout), 32'd0);
    check("por.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // 100, 200 back-to-back -> 50,100,150,200 with no gaps
    do_reset("b2b");
    bus.bypass = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.din = 8'd100;
    tick(); exp_out("b2b.o0", 1'b1, 8'd50);
    check("b2b.mid_in_ready", 32'(bus.in_ready), 32'd0);
    bus.din = 8'd200;
    tick(); exp_out("b2b.o1", 1'b1, 8'd100);
    check("b2b.cur_in_ready", 32'(bus.in_ready), 32'd1);
    tick(); exp_out("b2b.o2", 1'b1, 8'd150);
    bus.in_valid = 1'b0;
    tick(); exp_out("b2b.o3", 1'b1, 8'd200);
    tick(); exp_out("b2b.idle", 1'b0, 8'd0);

    // Rounding mode on odd sum 0+101
    do_reset("odd");
    bus.in_valid = 1'b1; bus.din = 8'd101;
    tick(); exp_out("odd.mid", 1'b1, Round ? 8'd51 : 8'd50);
    bus.in_valid = 1'b0;
    tick(); exp_out("odd.cur", 1'b1, 8'd101);
    tick(); exp_out("odd.idle", 1'b0, 8'd0);

    // 255,255 -> sum must not wrap
    do_reset("max");
    bus.in_valid = 1'b1; bus.din = 8'd255;
    tick(); exp_out("max.o0", 1'b1, Round ? 8'd128 : 8'd127);
    tick(); exp_out("max.o1", 1'b1, 8'd255);
    tick(); exp_out("max.o2", 1'b1, 8'd255);
    bus.in_valid = 1'b0;
    tick(); exp_out("max.o3", 1'b1, 8'd255);
    tick(); exp_out("max.idle", 1'b0, 8'd0);

    // Stall for 5 cycles in MID
    do_reset("stall");
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.din = 8'd10;
    tick(); exp_out("stall.mid", 1'b1, 8'd5);
    bus.din = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick(); exp_out($sformatf("stall.hold%0d", i), 1'b1, 8'd5);
      check($sformatf("stall.in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); exp_out("stall.cur", 1'b1, 8'd10);
    tick(); exp_out("stall.idle", 1'b0, 8'd0);

    // Bypass stream, then bypass dropped while holding in CUR
    do_reset("byp");
    bus.bypass = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.din = 8'd1;
    tick(); exp_out("byp.o1", 1'b1, 8'd1);
    check("byp.in_ready", 32'(bus.in_ready), 32'd1);
    bus.din = 8'd2;
    tick(); exp_out("byp.o2", 1'b1, 8'd2);
    bus.din = 8'd3;
    tick(); exp_out("byp.o3", 1'b1, 8'd3);
    bus.bypass = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); exp_out("byp.hold0", 1'b1, 8'd3);
    tick(); exp_out("byp.hold1", 1'b1, 8'd3);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.din = 8'd7;
    tick(); exp_out("byp.mid", 1'b1, 8'd5);
    bus.in_valid = 1'b0;
    tick(); exp_out("byp.cur", 1'b1, 8'd7);
    tick(); exp_out("byp.idle", 1'b0, 8'd0);

    // Async reset while in MID discards pending output
    do_reset("arst");
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.din = 8'd60;
    tick(); exp_out("arst.mid", 1'b1, 8'd30);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    do_reset("arst");
    bus.in_valid = 1'b1; bus.din = 8'd40;
    tick(); exp_out("arst.o0", 1'b1, 8'd20);
    bus.in_valid = 1'b0;
    tick(); exp_out("arst.o1", 1'b1, 8'd40);
    tick(); exp_out("arst.idle", 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interp2_lin.md
INTERP2_LIN -- requirements
Module: interp2_lin

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: bypass  input  1  1 = pass samples through 1:1 with no interpolation; sampled only when an input is accepted.
REQ-004 SHALL have port: in_valid  input  1  upstream sample valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept din this cycle; combinational from state and out_ready.
REQ-006 SHALL have port: din  input  8  unsigned input sample.
REQ-007 SHALL have port: out_valid  output  1  dout valid; registered.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts dout this cycle.
REQ-009 SHALL have port: dout  output  8  unsigned output sample; registered.

Function
REQ-010 SHALL upsample by 2: for each accepted input x[n], emit mid(x[n-1],x[n]) and then x[n], in that order.
REQ-011 SHALL define a transfer as valid&&ready on the same clock edge, for both the input and output sides.
REQ-012 SHALL hold internal registers prev[7:0] (last fully emitted sample) and cur[7:0] (sample in flight).
REQ-013 SHALL implement states IDLE, MID, CUR.
REQ-014 IDLE: out_valid=0, in_ready=1. On in_valid, cur<=din. If bypass=0: dout<=mid(prev,din), go to MID. If bypass=1: dout<=din, go to CUR. In both cases out_valid<=1.
REQ-015 MID: out_valid=1, in_ready=0. On out_ready: dout<=cur, go to CUR. Otherwise hold dout.
REQ-016 CUR: out_valid=1, in_ready=out_ready. On out_ready: prev<=cur. If in_valid is also high, load the new sample exactly as in IDLE (back-to-back). Otherwise out_valid<=0 and go to IDLE.
REQ-017 SHALL keep dout and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL never assert in_ready in MID. Input is never lost or duplicated.
REQ-019 Latency: input accepted at edge N makes its first output (midpoint, or the sample itself in bypass) valid after edge N.
REQ-020 Throughput with out_ready held at 1: one input every 2 cycles (interpolate) or 1 cycle (bypass), with no bubble on the output.
REQ-021 mid(a,b) SHALL be computed as a 9-bit sum a+b, right-shifted by 1, and truncated to 8 bits. It never overflows.
REQ-022 A change on bypass while in MID or CUR SHALL NOT alter pending outputs. It applies only at the next input acceptance.
REQ-023 After reset, the first interpolated midpoint SHALL use prev=0.

Reset
REQ-024 On rst_n low, SHALL asynchronously set state=IDLE, out_valid=0, dout=0, prev=0, cur=0.
REQ-025 Reset mid-operation SHALL discard the pending outputs. in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-026 Macro INTERP_ROUND_EN defined: mid(a,b) SHALL be (a+b+1)>>1, rounding half up.
REQ-027 Macro INTERP_ROUND_EN undefined: mid(a,b) SHALL be (a+b)>>1, truncating.

Verification
REQ-028 Reset, out_ready=1, bypass=0, send 100 then 200 back-to-back -> dout sequence 50,100,150,200, with no idle cycles between outputs.
REQ-029 prev=0, din=101 -> midpoint 50 without INTERP_ROUND_EN, 51 with it; then 101.
REQ-030 Send 255,255 -> outputs 127(/128 rounded),255,255,255; the 9-bit sum must not wrap.
REQ-031 out_ready=0 for 5 cycles while in MID -> dout and out_valid held, in_ready=0, no input accepted; on release the sequence resumes intact.
REQ-032 bypass=1, out_ready=1, stream 1,2,3 on consecutive cycles -> dout 1,2,3, one per cycle. Toggle bypass to 0 while in CUR holding 3, then send 7 -> outputs 5,7.
REQ-033 Assert rst_n low while in MID -> out_valid=0 and dout=0 immediately. After release, send 40 -> midpoint 20.
